// File: rtl/fast_pulse_gen.sv
// fast_pulse_gen: programmable periodic / one-shot pulse generator.
// A phase counter runs 0..period. When it equals match, a registered pulse
// of width+1 cycles follows. period/match/width/mode are shadowed and only
// change at run start or at a counter wrap.
// Optional feature macro: FAST_PULSE_TOGGLE_EN adds sig_tgl, which inverts
// once per rising edge of sig_o for 2-flop crossings into slow domains.
module fast_pulse_gen #(
    parameter int CNT_W = 8,
    parameter int PW_W  = 4
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             start,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] match,
    input  logic [PW_W-1:0]  width,
    output logic             sig_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             busy,
`ifdef FAST_PULSE_TOGGLE_EN
    output logic             sig_tgl,
`endif
    output logic             done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PW_W-1:0]  PW_ZERO  = {PW_W{1'b0}};
    localparam logic [PW_W-1:0]  PW_ONE   = {{(PW_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             sig_r, sig_nxt_s;
    logic [PW_W-1:0]  wcnt_r, wcnt_nxt_s;
    logic             done_r, done_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic [CNT_W-1:0] period_r, period_nxt_s;
    logic [CNT_W-1:0] match_r, match_nxt_s;
    logic [PW_W-1:0]  width_r, width_nxt_s;
    logic             mode_r, mode_nxt_s;
    logic             load_s;
`ifdef FAST_PULSE_TOGGLE_EN
    logic             tgl_r, tgl_nxt_s;
`endif

    // Next-state, counter, pulse stretcher and shadow-config computation.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        sig_nxt_s    = sig_r;
        wcnt_nxt_s   = wcnt_r;
        done_nxt_s   = 1'b0;
        period_nxt_s = period_r;
        match_nxt_s  = match_r;
        width_nxt_s  = width_r;
        mode_nxt_s   = mode_r;
        load_s       = 1'b0;

        // Running stretch counts down; it also finishes after a one-shot
        // run has returned to IDLE.
        if (sig_r) begin
            if (wcnt_r == PW_ZERO) begin
                sig_nxt_s = 1'b0;
            end else begin
                wcnt_nxt_s = wcnt_r - PW_ONE;
            end
        end else begin
            wcnt_nxt_s = wcnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (en && (!mode || start)) begin
                    state_nxt_s = ST_RUN;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A match (re)loads the stretch, so overlapping pulses merge.
                if (cnt_r == match_r) begin
                    sig_nxt_s  = 1'b1;
                    wcnt_nxt_s = width_r;
                end else begin
                    sig_nxt_s = sig_nxt_s;
                end
                if (cnt_r == period_r) begin
                    cnt_nxt_s = CNT_ZERO;
                    load_s    = 1'b1;
                    if (mode_r) begin
                        state_nxt_s = ST_IDLE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase

        // Dropping the enable wins over wrap and match in the same cycle.
        if (!en) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
            sig_nxt_s   = 1'b0;
            wcnt_nxt_s  = PW_ZERO;
            done_nxt_s  = 1'b0;
        end else if (load_s) begin
            period_nxt_s = period;
            match_nxt_s  = match;
            width_nxt_s  = width;
            mode_nxt_s   = mode;
        end else begin
            period_nxt_s = period_r;
        end

        busy_nxt_s = (state_nxt_s != ST_IDLE) || sig_nxt_s;
    end

`ifdef FAST_PULSE_TOGGLE_EN
    // Toggle flag flips only when the pulse rises, not on retrigger.
    always_comb begin
        tgl_nxt_s = tgl_r;
        if (sig_nxt_s && !sig_r) begin
            tgl_nxt_s = ~tgl_r;
        end else begin
            tgl_nxt_s = tgl_r;
        end
    end
`endif

    // State, counter, pulse, strobes and shadow registers with sync reset.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            sig_r    <= 1'b0;
            wcnt_r   <= PW_ZERO;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            period_r <= CNT_ZERO;
            match_r  <= CNT_ZERO;
            width_r  <= PW_ZERO;
            mode_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            sig_r    <= sig_nxt_s;
            wcnt_r   <= wcnt_nxt_s;
            done_r   <= done_nxt_s;
            busy_r   <= busy_nxt_s;
            period_r <= period_nxt_s;
            match_r  <= match_nxt_s;
            width_r  <= width_nxt_s;
            mode_r   <= mode_nxt_s;
        end
    end

`ifdef FAST_PULSE_TOGGLE_EN
    // Toggle register for slow-domain crossing.
    always_ff @(posedge clk1) begin
        if (rst) begin
            tgl_r <= 1'b0;
        end else begin
            tgl_r <= tgl_nxt_s;
        end
    end

    assign sig_tgl = tgl_r;
`endif

    assign sig_o = sig_r;
    assign cnt_o = cnt_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_fast_pulse_gen.sv
// Directed self-checking bench for fast_pulse_gen (CNT_W=4, PW_W=4).
module tb_fast_pulse_gen;

    logic       clk1;
    logic       rst;
    logic       en;
    logic       mode;
    logic       start;
    logic [3:0] period;
    logic [3:0] match;
    logic [3:0] width;
    logic       sig_o;
    logic [3:0] cnt_o;
    logic       busy;
    logic       done;
`ifdef FAST_PULSE_TOGGLE_EN
    logic       sig_tgl;
`endif

    int checks;
    int errors;

    fast_pulse_gen #(.CNT_W(4), .PW_W(4)) dut (
        .clk1   (clk1),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .start  (start),
        .period (period),
        .match  (match),
        .width  (width),
        .sig_o  (sig_o),
        .cnt_o  (cnt_o),
        .busy   (busy),
`ifdef FAST_PULSE_TOGGLE_EN
        .sig_tgl(sig_tgl),
`endif
        .done   (done)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int os_cnt [8];
        int os_sig [8];
        int os_done[8];
        int os_busy[8];
        int sh_cnt [11];

        os_cnt  = '{0, 1, 2, 3, 4, 5, 0, 0};
        os_sig  = '{0, 0, 0, 1, 1, 1, 0, 0};
        os_done = '{0, 0, 0, 0, 0, 0, 1, 0};
        os_busy = '{1, 1, 1, 1, 1, 1, 0, 0};
        sh_cnt  = '{3, 4, 5, 6, 7, 0, 1, 2, 3, 0, 1};

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        en     = 1'b0;
        mode   = 1'b0;
        start  = 1'b0;
        period = 4'd15;
        match  = 4'd9;
        width  = 4'd0;

        // Reset state.
        step();
        chk("rst_cnt", 32'(cnt_o), 32'd0);
        chk("rst_sig", 32'(sig_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Legacy: 1-cycle pulse the cycle after cnt==9, every 16 cycles.
        rst = 1'b0;
        en  = 1'b1;
        step();
        chk("leg_cnt0", 32'(cnt_o), 32'd0);
        chk("leg_busy0", 32'(busy), 32'd1);
        for (int i = 1; i <= 40; i++) begin
            step();
            chk("leg_cnt", 32'(cnt_o), 32'(i % 16));
            chk("leg_sig", 32'(sig_o), ((i % 16) == 10) ? 32'd1 : 32'd0);
            chk("leg_busy", 32'(busy), 32'd1);
        end

        // Reset mid-run, then restart from cnt 0 with en held high.
        rst = 1'b1;
        step();
        chk("mrst_cnt", 32'(cnt_o), 32'd0);
        chk("mrst_sig", 32'(sig_o), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        step();
        chk("rel_cnt", 32'(cnt_o), 32'd0);
        chk("rel_busy", 32'(busy), 32'd1);

        // Abort while the pulse is high.
        for (int i = 0; i < 10; i++) begin
            step();
        end
        chk("ab_pre_cnt", 32'(cnt_o), 32'd10);
        chk("ab_pre_sig", 32'(sig_o), 32'd1);
        en = 1'b0;
        step();
        chk("ab_sig", 32'(sig_o), 32'd0);
        chk("ab_cnt", 32'(cnt_o), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);

        // One-shot: period 5, match 2, width 2.
        en     = 1'b1;
        mode   = 1'b1;
        start  = 1'b1;
        period = 4'd5;
        match  = 4'd2;
        width  = 4'd2;
        for (int i = 0; i < 8; i++) begin
            step();
            start = 1'b0;
            chk("os_cnt", 32'(cnt_o), 32'(os_cnt[i]));
            chk("os_sig", 32'(sig_o), 32'(os_sig[i]));
            chk("os_done", 32'(done), 32'(os_done[i]));
            chk("os_busy", 32'(busy), 32'(os_busy[i]));
        end

        // One-shot with match==period: done and pulse rise together,
        // busy held until the stretch ends.
        period = 4'd3;
        match  = 4'd3;
        width  = 4'd1;
        start  = 1'b1;
        step();
        start = 1'b0;
        chk("mp_cnt0", 32'(cnt_o), 32'd0);
        step();
        step();
        step();
        chk("mp_cnt3", 32'(cnt_o), 32'd3);
        step();
        chk("mp_done", 32'(done), 32'd1);
        chk("mp_sig", 32'(sig_o), 32'd1);
        chk("mp_cnt", 32'(cnt_o), 32'd0);
        chk("mp_busy", 32'(busy), 32'd1);
        step();
        chk("mp_done2", 32'(done), 32'd0);
        chk("mp_sig2", 32'(sig_o), 32'd1);
        chk("mp_busy2", 32'(busy), 32'd1);
        step();
        chk("mp_sig3", 32'(sig_o), 32'd0);
        chk("mp_busy3", 32'(busy), 32'd0);

        // Shadow update: period change mid-run takes effect after wrap.
        mode   = 1'b0;
        period = 4'd7;
        match  = 4'd9;
        width  = 4'd0;
        step();
        chk("sh_cnt0", 32'(cnt_o), 32'd0);
        step();
        step();
        chk("sh_cnt2", 32'(cnt_o), 32'd2);
        period = 4'd3;
        for (int i = 0; i < 11; i++) begin
            step();
            chk("sh_cnt", 32'(cnt_o), 32'(sh_cnt[i]));
            chk("sh_sig", 32'(sig_o), 32'd0);
        end

        // Retrigger: match 1, width 7 with period 3 keeps sig_o high.
        match = 4'd1;
        width = 4'd7;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rt_pre_sig", 32'(sig_o), 32'd0);
        end
        step();
        chk("rt_rise_cnt", 32'(cnt_o), 32'd2);
        chk("rt_rise_sig", 32'(sig_o), 32'd1);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("rt_hold_sig", 32'(sig_o), 32'd1);
        end

        // No-pulse: match 9 > period; stretch runs out and never restarts.
        match = 4'd9;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("np_tail_sig", 32'(sig_o), 32'd1);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            chk("np_off_sig", 32'(sig_o), 32'd0);
            chk("np_busy", 32'(busy), 32'd1);
        end

        // Three 1-cycle pulses with period 3, match 1 (toggle check when built).
        rst   = 1'b1;
        step();
`ifdef FAST_PULSE_TOGGLE_EN
        chk("tg_rst", 32'(sig_tgl), 32'd0);
`endif
        rst   = 1'b0;
        en    = 1'b1;
        mode  = 1'b0;
        match = 4'd1;
        width = 4'd0;
        for (int i = 1; i <= 11; i++) begin
            step();
            chk("tg_sig", 32'(sig_o), ((i == 3) || (i == 7) || (i == 11)) ? 32'd1 : 32'd0);
`ifdef FAST_PULSE_TOGGLE_EN
            chk("tg_tgl", 32'(sig_tgl), 32'((i >= 3) ^ (i >= 7) ^ (i >= 11)));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
